lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store per handshake from the core's execute stage and drives the dmem bus (enable/rnw/word address/wdata), which reads combinationally and writes on the clock edge. Handles byte/halfword/word access, sign/zero extension, alignment and range checks, and sub-word stores via read-modify-write. Returns one response pulse per accepted request.

## Interface
- DMEM_WORDS, 1024: dmem depth in 32-bit words; word index ≥ DMEM_WORDS is out of range.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error).
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, reserved size, or out of range.
- dmem_enable  out  1  memory access valid.
- dmem_rnw  out  1  1 = read, 0 = write.
- dmem_addr  out  32  word-aligned byte address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  full write word.
- dmem_rdata  in  32  combinational read data.
- dmem_status  in  1  1 = memory completes this cycle; 0 = wait.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: req_ready=1. On req_valid, register addr/size/we/unsigned/wdata, then:
  - error check (misaligned half addr[0]=1; word addr[1:0]≠0; size=3; addr[31:2] ≥ DMEM_WORDS) → RESP with err=1; no dmem access.
  - load → LOAD. Word store → STORE. Byte/half store → RMW_RD.
- LOAD: enable=1, rnw=1. If status=1: capture extracted word, → RESP; else stay.
- RMW_RD: enable=1, rnw=1. If status=1: capture dmem_rdata into merge register, → STORE; else stay.
- STORE: enable=1, rnw=0, wdata = merged word (word store: req_wdata). If status=1 → RESP; else stay, outputs held.
- RESP: resp_valid=1 for exactly one cycle, → IDLE. No response backpressure.
- Lane select: byte lane = addr[1:0] (bits 8*lane+7:8*lane); half lane = addr[1] (bits 16*addr[1]+15:16*addr[1]).
- Load extract: selected lane, bit 7/15 replicated (signed) or zeros (unsigned); word passes through.
- Store merge: only the selected lane replaced by req_wdata[7:0]/[15:0]; other bytes keep read value.
- Outside LOAD/RMW_RD/STORE: dmem_enable=0, dmem_rnw=1, dmem_addr=0, dmem_wdata=0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dmem_enable=0, dmem_rnw=1, dmem_addr=0, dmem_wdata=0.
- Accept on edge N (status=1 throughout): error → resp in cycle N+1; load or word store → N+2; sub-word store → N+3. Each status=0 cycle adds one.
- At most one outstanding request; req_ready=0 from accept until return to IDLE.
- resp_rdata/resp_err valid only while resp_valid=1; 0 otherwise.
- reset_n asserted mid-operation: immediate return to IDLE, dmem_enable drops asynchronously, no response; reset between RMW_RD and STORE leaves memory unchanged.
- Request inputs ignored while req_ready=0.

## Structure
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum, lane-select helper constants.
- Sub-module lsu_lane_align: combinational load extract/extend and store merge; FSM and registers stay in lsu.

## Test plan
- Word 1 = 0x0000ABCD; LW addr 0x4 → resp_valid at N+2, rdata 0x0000ABCD, err 0.
- Same word; LB addr 0x5 → 0xFFFFFFAB; LBU addr 0x5 → 0x000000AB; LHU addr 0x4 → 0x0000ABCD.
- SB addr 0x6, wdata 0x11 → RMW_RD read at N+1, write 0x0011ABCD at N+2, resp at N+3; re-read word 1 = 0x0011ABCD.
- LH addr 0x3 → resp at N+1, err 1, rdata 0, dmem_enable never high; LW addr 0x1000 (DMEM_WORDS=1024) → err 1.
- LW with dmem_status=0 for 2 cycles in LOAD → dmem_addr held, resp at N+4 with correct data.
- SH addr 0x4: reset_n low during STORE cycle (before edge) → no write, no resp_valid; after release req_ready=1, word 1 unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and lane masks
// shared by the load/store unit and its bench.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_R = 2'd3;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
   localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_RD,
      S_STORE,
      S_RESP
   } lsu_state_e;

   function automatic logic bad_shape(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      return (size == SZ_H && lo[0])
          || (size == SZ_W && lo != 2'b00)
          || (size == SZ_R);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and dmem bus bundle
// for the load/store unit.
interface lsu_core_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned,
      output req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned,
      input  req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_dmem_if;
   logic        dmem_enable;
   logic        dmem_rnw;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_status;

   modport master (
      output dmem_enable, dmem_rnw, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_status
   );

   modport slave (
      input  dmem_enable, dmem_rnw, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_status
   );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extract/extend and sub-word
// store merge into a previously read word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] ld_word_i,
   input  logic [31:0] old_word_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [4:0]  b_sh;
   logic [4:0]  h_sh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask;
   logic [31:0] rep;

   always_comb begin
      b_sh      = {lane_i, 3'b000};
      h_sh      = {lane_i[1], 4'b0000};
      b         = 8'(ld_word_i >> b_sh);
      h         = 16'(ld_word_i >> h_sh);
      ld_data_o = ld_word_i;
      mask      = '1;
      rep       = st_data_i;
      unique case (size_i)
         SZ_B: begin
            ld_data_o = uns_i ? {24'h0, b} : {{24{b[7]}}, b};
            mask      = BYTE_MASK << b_sh;
            rep       = {4{st_data_i[7:0]}};
         end
         SZ_H: begin
            ld_data_o = uns_i ? {16'h0, h} : {{16{h[15]}}, h};
            mask      = HALF_MASK << h_sh;
            rep       = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
      // replicated data lands in every lane; mask keeps only the target
      st_word_o = (old_word_i & ~mask) | (rep & mask);
   end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving the dmem bus, one request
// in flight, sub-word stores via read-modify-write.
module lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_WORDS = 1024
)(
   input  logic       clk,
   input  logic       reset_n,
   lsu_core_if.slave  core,
   lsu_dmem_if.master dmem
);

   localparam logic [29:0] WORD_LIM = 30'(DMEM_WORDS);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] ld_data;
   logic [31:0] st_word;
   logic [31:0] word_addr;

   assign word_addr = {addr_q[31:2], 2'b00};

   lsu_lane_align u_align (
      .size_i     (size_q),
      .uns_i      (uns_q),
      .lane_i     (addr_q[1:0]),
      .ld_word_i  (dmem.dmem_rdata),
      .old_word_i (merge_q),
      .st_data_i  (wdata_q),
      .ld_data_o  (ld_data),
      .st_word_o  (st_word)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      size_d           = size_q;
      we_d             = we_q;
      uns_d            = uns_q;
      wdata_d          = wdata_q;
      merge_d          = merge_q;
      rdata_d          = rdata_q;
      err_d            = err_q;
      core.req_ready   = 1'b0;
      core.resp_valid  = 1'b0;
      core.resp_rdata  = '0;
      core.resp_err    = 1'b0;
      dmem.dmem_enable = 1'b0;
      dmem.dmem_rnw    = 1'b1;
      dmem.dmem_addr   = '0;
      dmem.dmem_wdata  = '0;
      unique case (state_q)
         S_IDLE: begin
            core.req_ready = 1'b1;
            if (core.req_valid) begin
               addr_d  = core.req_addr;
               size_d  = core.req_size;
               we_d    = core.req_we;
               uns_d   = core.req_unsigned;
               wdata_d = core.req_wdata;
               rdata_d = '0;
               err_d   = bad_shape(core.req_size, core.req_addr[1:0])
                      || (core.req_addr[31:2] >= WORD_LIM);
               if (err_d)
                  state_d = S_RESP;
               else if (!core.req_we)
                  state_d = S_LOAD;
               else if (core.req_size == SZ_W)
                  state_d = S_STORE;
               else
                  state_d = S_RMW_RD;
            end
         end
         S_LOAD: begin
            dmem.dmem_enable = 1'b1;
            dmem.dmem_addr   = word_addr;
            if (dmem.dmem_status) begin
               rdata_d = ld_data;
               state_d = S_RESP;
            end
         end
         S_RMW_RD: begin
            dmem.dmem_enable = 1'b1;
            dmem.dmem_addr   = word_addr;
            if (dmem.dmem_status) begin
               merge_d = dmem.dmem_rdata;
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            dmem.dmem_enable = 1'b1;
            dmem.dmem_rnw    = 1'b0;
            dmem.dmem_addr   = word_addr;
            dmem.dmem_wdata  = st_word;
            if (dmem.dmem_status)
               state_d = S_RESP;
         end
         S_RESP: begin
            core.resp_valid = 1'b1;
            core.resp_rdata = rdata_q;
            core.resp_err   = err_q;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= SZ_B;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed load/store sequence against a small
// combinational-read dmem model with stall control.
module tb_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   logic status;
   logic init_mem;
   int   tests = 0;
   int   fails = 0;
   logic [31:0] mem [0:1023];

   lsu_core_if core_if ();
   lsu_dmem_if dmem_if ();

   lsu #(.DMEM_WORDS(1024)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .core    (core_if),
      .dmem    (dmem_if)
   );

   always #5 clk = ~clk;

   assign dmem_if.dmem_rdata  = mem[dmem_if.dmem_addr[11:2]];
   assign dmem_if.dmem_status = status;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem[1] <= 32'h0000_ABCD;
      end else if (dmem_if.dmem_enable && !dmem_if.dmem_rnw && status) begin
         mem[dmem_if.dmem_addr[11:2]] <= dmem_if.dmem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // issue one request; status low for the first `stall` busy cycles
   task automatic run(input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall,
                      output int lat, output logic [31:0] rd,
                      output logic er, output int rl, output int wl,
                      output logic se);
      int k;
      logic done;
      lat = 0; rd = 'x; er = 1'bx; rl = 0; wl = 0; se = 1'b0;
      @(negedge clk);
      core_if.req_valid    = 1'b1;
      core_if.req_we       = we;
      core_if.req_size     = size;
      core_if.req_unsigned = uns;
      core_if.req_addr     = addr;
      core_if.req_wdata    = wd;
      chk("ready_at_issue", 32'(core_if.req_ready), 32'd1);
      @(posedge clk);
      #1;
      core_if.req_valid = 1'b0;
      k = 0;
      done = 1'b0;
      while (!done && k < 30) begin
         k++;
         status = (k > stall);
         @(negedge clk);
         if (dmem_if.dmem_enable) begin
            se = 1'b1;
            chk("dmem_addr_held", dmem_if.dmem_addr, {addr[31:2], 2'b00});
            if (dmem_if.dmem_rnw && rl == 0) rl = k;
            if (!dmem_if.dmem_rnw && wl == 0) wl = k;
         end
         if (core_if.resp_valid) begin
            done = 1'b1;
            lat  = k;
            rd   = core_if.resp_rdata;
            er   = core_if.resp_err;
         end
         @(posedge clk);
         #1;
      end
      status = 1'b1;
      if (!done) begin
         tests++;
         fails++;
         $error("FAIL resp_timeout: observed no resp_valid expected a response");
      end
   endtask

   initial begin
      int lat, rl, wl;
      logic [31:0] rd;
      logic er, se;

      reset_n = 1'b0;
      init_mem = 1'b1;
      status = 1'b1;
      core_if.req_valid = 1'b0;
      core_if.req_we = 1'b0;
      core_if.req_size = SZ_W;
      core_if.req_unsigned = 1'b0;
      core_if.req_addr = '0;
      core_if.req_wdata = '0;

      @(negedge clk);
      chk("rst_ready", 32'(core_if.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(core_if.resp_valid), 32'd0);
      chk("rst_rdata", core_if.resp_rdata, 32'd0);
      chk("rst_err", 32'(core_if.resp_err), 32'd0);
      chk("rst_enable", 32'(dmem_if.dmem_enable), 32'd0);
      chk("rst_rnw", 32'(dmem_if.dmem_rnw), 32'd1);
      chk("rst_addr", dmem_if.dmem_addr, 32'd0);
      chk("rst_wdata", dmem_if.dmem_wdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      init_mem = 1'b0;

      run(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_data", rd, 32'h0000_ABCD);
      chk("lw_err", 32'(er), 32'd0);

      run(1'b0, SZ_B, 1'b0, 32'h5, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lb_5", rd, 32'hFFFF_FFAB);
      run(1'b0, SZ_B, 1'b1, 32'h5, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lbu_5", rd, 32'h0000_00AB);
      run(1'b0, SZ_H, 1'b1, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lhu_4", rd, 32'h0000_ABCD);
      run(1'b0, SZ_H, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lh_4", rd, 32'hFFFF_ABCD);
      run(1'b0, SZ_B, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lb_4", rd, 32'hFFFF_FFCD);

      run(1'b1, SZ_B, 1'b0, 32'h6, 32'hAAAA_AA11, 0, lat, rd, er, rl, wl, se);
      chk("sb_rd_cycle", 32'(rl), 32'd1);
      chk("sb_wr_cycle", 32'(wl), 32'd2);
      chk("sb_lat", 32'(lat), 32'd3);
      chk("sb_rdata", rd, 32'd0);
      chk("sb_err", 32'(er), 32'd0);
      chk("sb_mem", mem[1], 32'h0011_ABCD);
      run(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("sb_reread", rd, 32'h0011_ABCD);

      @(negedge clk);
      core_if.req_valid = 1'b1;
      core_if.req_we = 1'b1;
      core_if.req_size = SZ_H;
      core_if.req_unsigned = 1'b0;
      core_if.req_addr = 32'h4;
      core_if.req_wdata = 32'h0000_2222;
      @(posedge clk);
      #1;
      core_if.req_valid = 1'b0;
      @(negedge clk);
      chk("rst_rmw_en", 32'(dmem_if.dmem_enable), 32'd1);
      chk("rst_rmw_rnw", 32'(dmem_if.dmem_rnw), 32'd1);
      @(negedge clk);
      chk("rst_st_rnw", 32'(dmem_if.dmem_rnw), 32'd0);
      chk("rst_st_wdata", dmem_if.dmem_wdata, 32'h0011_2222);
      reset_n = 1'b0;
      #1;
      chk("rst_async_en", 32'(dmem_if.dmem_enable), 32'd0);
      chk("rst_async_resp", 32'(core_if.resp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_resp", 32'(core_if.resp_valid), 32'd0);
      end
      chk("rst_ready_after", 32'(core_if.req_ready), 32'd1);
      chk("rst_mem_kept", mem[1], 32'h0011_ABCD);
      run(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("rst_reread", rd, 32'h0011_ABCD);

      run(1'b0, SZ_H, 1'b0, 32'h3, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lh_mis_lat", 32'(lat), 32'd1);
      chk("lh_mis_err", 32'(er), 32'd1);
      chk("lh_mis_rdata", rd, 32'd0);
      chk("lh_mis_noacc", 32'(se), 32'd0);
      run(1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lw_oor_err", 32'(er), 32'd1);
      chk("lw_oor_noacc", 32'(se), 32'd0);
      run(1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lw_last_err", 32'(er), 32'd0);
      chk("lw_last_lat", 32'(lat), 32'd2);
      run(1'b0, SZ_R, 1'b0, 32'h0, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("size3_err", 32'(er), 32'd1);
      run(1'b1, SZ_W, 1'b0, 32'h2, 32'h1234_5678, 0, lat, rd, er, rl, wl, se);
      chk("sw_mis_err", 32'(er), 32'd1);
      chk("sw_mis_noacc", 32'(se), 32'd0);

      run(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 2, lat, rd, er, rl, wl, se);
      chk("lw_stall_lat", 32'(lat), 32'd4);
      chk("lw_stall_data", rd, 32'h0011_ABCD);

      run(1'b1, SZ_W, 1'b0, 32'h8, 32'hDEAD_BEEF, 0, lat, rd, er, rl, wl, se);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_wr_cycle", 32'(wl), 32'd1);
      chk("sw_mem", mem[2], 32'hDEAD_BEEF);
      run(1'b0, SZ_B, 1'b1, 32'hB, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lbu_b", rd, 32'h0000_00DE);

      run(1'b1, SZ_H, 1'b0, 32'h6, 32'hFFFF_5566, 0, lat, rd, er, rl, wl, se);
      chk("sh_lat", 32'(lat), 32'd3);
      run(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("sh_reread", rd, 32'h5566_ABCD);
      run(1'b0, SZ_H, 1'b0, 32'h6, 32'h0, 0, lat, rd, er, rl, wl, se);
      chk("lh_6", rd, 32'h0000_5566);

      run(1'b1, SZ_B, 1'b0, 32'h9, 32'h0000_0077, 1, lat, rd, er, rl, wl, se);
      chk("sb_stall_lat", 32'(lat), 32'd4);
      chk("sb_stall_mem", mem[2], 32'hDEAD_77EF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
